// File: rtl/ring_monitor.sv
// Lock monitor for a periodic one-cycle tick stream: tracks the tick phase,
// declares lock after a run of good periods and counts lock violations.
module ring_monitor #(
  parameter int C_NUM_CYCLES = 4,
  parameter int C_LOCK_COUNT = 3
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       CLR_ERR,
  output logic       LOCKED,
  output logic       ERR,
  output logic [7:0] ERR_CNT,
  output logic [1:0] STATE
);

  localparam int GW = $clog2(C_NUM_CYCLES + 2);
  localparam int KW = (C_LOCK_COUNT < 1) ? 1 : $clog2(C_LOCK_COUNT + 1);
  localparam logic [GW-1:0] G_TGT  = GW'(C_NUM_CYCLES);
  localparam logic [GW-1:0] G_SAT  = GW'(C_NUM_CYCLES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(C_LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [KW-1:0]   k_q, k_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            good, bad, miss, viol;

  // A tick always wins over the missing-tick condition, and is judged by
  // the current gap value even when the gap counter is about to saturate.
  assign good = TICK  && (g_q == G_TGT);
  assign bad  = TICK  && (g_q != G_TGT);
  assign miss = !TICK && (g_q == G_TGT);

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      k_q      <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      k_q      <= k_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    viol    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TICK) begin
          state_d = S_ACQ;
          k_d     = '0;
        end
      end
      S_ACQ: begin
        if (good) begin
          k_d = k_q + KW'(1);
          if (k_q == K_LAST) state_d = S_LOCK;
        end else if (bad) begin
          k_d = '0;
        end else if (miss) begin
          state_d = S_IDLE;
          k_d     = '0;
        end
      end
      S_LOCK: begin
        if (bad) begin
          state_d = S_ACQ;
          k_d     = '0;
          viol    = 1'b1;
        end else if (miss) begin
          state_d = S_IDLE;
          k_d     = '0;
          viol    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_comb begin
    g_d = g_q;
    if (TICK)               g_d = GW'(1);
    else if (g_q != G_SAT)  g_d = g_q + GW'(1);

    locked_d = (state_d == S_LOCK);
    err_d    = viol;

    // A clear coinciding with a violation still records that violation.
    cnt_d = cnt_q;
    if (CLR_ERR)                   cnt_d = viol ? 8'd1 : 8'd0;
    else if (viol && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    LOCKED  = locked_q;
    ERR     = err_q;
    ERR_CNT = cnt_q;
    STATE   = state_q;
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Directed bench for ring_monitor (C_NUM_CYCLES=4, C_LOCK_COUNT=3).
module tb_ring_monitor;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic       TICK = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       LOCKED, ERR;
  logic [7:0] ERR_CNT;
  logic [1:0] STATE;

  int checks = 0;
  int failures = 0;

  ring_monitor #(.C_NUM_CYCLES(4), .C_LOCK_COUNT(3)) dut (
    .CK(CK), .RST(RST), .TICK(TICK), .CLR_ERR(CLR_ERR),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_CNT(ERR_CNT), .STATE(STATE)
  );

  always #5 CK = ~CK;

  typedef struct {
    int         n;
    logic       tick;
    logic       clr;
    logic [1:0] st;
    logic       lk;
    logic       er;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, logic tick, logic clr, logic [1:0] st,
                              logic lk, logic er, logic [7:0] cnt);
    vec_t v;
    v.n = n; v.tick = tick; v.clr = clr; v.st = st; v.lk = lk; v.er = er; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int lk, input int er, input int cnt);
    chk({tag, ".STATE"}, STATE, st);
    chk({tag, ".LOCKED"}, LOCKED, lk);
    chk({tag, ".ERR"}, ERR, er);
    chk({tag, ".ERR_CNT"}, ERR_CNT, cnt);
  endtask

  // Drive inputs on the falling edge, sample just after the rising edge.
  task automatic step(input logic tick, input logic clr);
    @(negedge CK);
    TICK = tick;
    CLR_ERR = clr;
    @(posedge CK);
    #1;
  endtask

  // One lock violation (tick at the wrong phase), then three good periods.
  task automatic viol_relock(input logic clr, output int cnt, output int er);
    step(1'b1, clr);
    cnt = ERR_CNT;
    er = ERR;
    for (int p = 0; p < 3; p++) begin
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
  endtask

  initial begin
    int c, e;
    // n, tick, clr, state, locked, err, cnt
    add(1,1,0,1,0,0,0);                      // c0: phase only
    add(3,0,0,1,0,0,0); add(1,1,0,1,0,0,0);  // c4 K=1
    add(3,0,0,1,0,0,0); add(1,1,0,1,0,0,0);  // c8 K=2
    add(3,0,0,1,0,0,0); add(1,1,0,2,1,0,0);  // c12 lock
    add(3,0,0,2,1,0,0); add(1,1,0,2,1,0,0);  // c16 good
    add(2,0,0,2,1,0,0); add(1,1,0,1,0,1,1);  // c19 early tick
    add(1,0,0,1,0,0,1); add(2,0,0,1,0,0,1);
    add(1,1,0,1,0,0,1);                      // c23 K=1
    add(3,0,0,1,0,0,1); add(1,1,0,1,0,0,1);
    add(3,0,0,1,0,0,1); add(1,1,0,2,1,0,1);  // c31 relock
    add(3,0,0,2,1,0,1); add(1,0,0,0,0,1,2);  // c35 missing tick
    add(5,0,0,0,0,0,2);                      // absent ticks: no more errors
    add(1,1,0,1,0,0,2); add(3,0,0,1,0,0,2);
    add(1,0,0,0,0,0,2);                      // missing in ACQ: silent
    add(2,0,0,0,0,0,2);
    add(1,1,0,1,0,0,2); add(3,0,0,1,0,0,2);  // c48 phase
    add(1,1,0,1,0,0,2);                      // c52 K=1
    add(1,1,0,1,0,0,2);                      // c53 back-to-back: K=0
    add(3,0,0,1,0,0,2); add(1,1,0,1,0,0,2);
    add(3,0,0,1,0,0,2); add(1,1,0,1,0,0,2);
    add(3,0,0,1,0,0,2); add(1,1,0,2,1,0,2);  // c65 lock
    add(1,0,1,2,1,0,0);                      // clear alone

    RST = 1'b0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge CK);
    RST = 1'b1;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].n; r++) begin
        step(tbl[i].tick, tbl[i].clr);
        chk_all($sformatf("vec%0d.%0d", i, r), tbl[i].st, tbl[i].lk, tbl[i].er, tbl[i].cnt);
      end
    end

    // Saturation of the violation counter.
    for (int it = 1; it <= 300; it++) begin
      viol_relock(1'b0, c, e);
      if (it == 1)   chk("sat.first_cnt", c, 1);
      if (it == 300) begin
        chk("sat.cnt255", c, 255);
        chk("sat.err", e, 1);
      end
    end
    chk("sat.relocked", STATE, 2);
    viol_relock(1'b1, c, e);
    chk("clrviol.cnt", c, 1);
    chk("clrviol.err", e, 1);
    step(1'b0, 1'b1);
    chk("clr.cnt", ERR_CNT, 0);
    chk("clr.state", STATE, 2);

    // Asynchronous reset while locked with a nonzero count.
    viol_relock(1'b0, c, e);
    chk("prerst.cnt", c, 1);
    chk("prerst.locked", LOCKED, 1);
    @(negedge CK);
    #2 RST = 1'b0;
    #1 chk_all("rst_async", 0, 0, 0, 0);
    TICK = 1'b1;
    @(posedge CK);
    #1 chk_all("rst_hold", 0, 0, 0, 0);
    @(negedge CK);
    RST = 1'b1;
    TICK = 1'b0;
    step(1'b0, 1'b0);
    chk_all("rst_after", 0, 0, 0, 0);
    step(1'b1, 1'b0);
    chk_all("rst_phase", 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      if (p < 2) chk_all($sformatf("rst_acq%0d", p), 1, 0, 0, 0);
      else       chk_all("rst_relock", 2, 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
